// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period,
// used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so that a second
// byte can be queued while a frame is on the line (back-to-back frames).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [7:0] i_data_byte,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic        accept;
  logic        bit_end;

  // Ready depends on registered state only, never on i_data_valid.
  assign o_ready = ~hold_full_q;
  assign accept  = i_data_valid & ~hold_full_q;
  assign bit_end = (cnt_q == CNT_LAST);

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

  // Line outputs are registered from the current state, so the serial
  // waveform trails the state register by one cycle throughout.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        hold_q      <= i_data_byte;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          cnt_q     <= 16'd0;
          bit_idx_q <= 3'd0;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            state_q     <= ST_START;
          end
        end

        ST_START: begin
          tx_q   <= 1'b0;
          busy_q <= 1'b1;
          if (bit_end) begin
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            state_q   <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_DATA: begin
          tx_q   <= shift_q[bit_idx_q];
          busy_q <= 1'b1;
          if (bit_end) begin
            cnt_q <= 16'd0;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_STOP: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b1;
          if (bit_end) begin
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            done_q    <= 1'b1;
            // A queued byte goes straight into its start bit with no idle gap.
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              state_q     <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          cnt_q     <= 16'd0;
          bit_idx_q <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-timing reference model checked every cycle at
// CLKS_PER_BIT=4, plus a run-length/decode check of one frame at 868.
module tb_uart_tx;

  localparam int C     = 4;
  localparam int C2    = 868;
  localparam int LOG_N = 8700;

  logic       clock;
  logic       rst_n;
  logic [7:0] d;
  logic       v;
  logic       ready, tx, busy, done;
  logic [7:0] d2;
  logic       v2;
  logic       ready2, tx2, busy2, done2;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clock(clock), .rst_n(rst_n),
    .i_data_byte(d), .i_data_valid(v),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_done(done)
  );

  uart_tx #(.CLKS_PER_BIT(C2)) dut2 (
    .clock(clock), .rst_n(rst_n),
    .i_data_byte(d2), .i_data_valid(v2),
    .o_ready(ready2), .o_tx(tx2), .o_busy(busy2), .o_done(done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  // Reference model: each accepted byte owns a 10*C-cycle window starting
  // two edges after acceptance, or right when the previous window ends.
  typedef struct {
    longint     s;
    logic [7:0] b;
  } frame_t;

  frame_t fq[$];
  longint t          = 0;
  longint last_end   = 0;
  longint hold_until = 0;
  bit     have_hold  = 0;
  bit     exp_ready  = 1;
  bit     acc_last   = 0;
  logic   exp_tx, exp_busy, exp_done;

  logic tx2_log [0:LOG_N-1];

  task automatic cmp_bit(input string name, input logic got, input logic exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s t=%0d observed=%b expected=%b", name, t, got, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    t++;
    acc_last = 0;
    if (!rst_n) begin
      fq.delete();
      have_hold = 0;
      last_end  = 0;
    end else if (v && exp_ready) begin
      frame_t f;
      f.s = (t + 2 > last_end) ? t + 2 : last_end;
      f.b = d;
      fq.push_back(f);
      last_end   = f.s + 10 * C;
      have_hold  = 1;
      hold_until = f.s - 1;
      acc_last   = 1;
    end
    if (have_hold && t >= hold_until) have_hold = 0;
    while (fq.size() > 0 && t >= fq[0].s + 10 * C) void'(fq.pop_front());
    exp_ready = !have_hold;
    exp_tx    = 1'b1;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    if (fq.size() > 0 && t >= fq[0].s) begin
      int k;
      k = int'((t - fq[0].s) / C);
      exp_busy = 1'b1;
      if (k == 0)      exp_tx = 1'b0;
      else if (k == 9) exp_tx = 1'b1;
      else             exp_tx = fq[0].b[k-1];
      exp_done = (t == fq[0].s + 10 * C - 1);
    end
    #1;
    cmp_bit("tx", tx, exp_tx);
    cmp_bit("busy", busy, exp_busy);
    cmp_bit("done", done, exp_done);
    cmp_bit("ready", ready, exp_ready);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    v = 1'b1;
    d = b;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 200);
    cmp_bit("accept_timeout", acc_last, 1'b1);
    v = 1'b0;
  endtask

  initial begin
    int n, f, pos, len, busy_cnt, done_cnt;
    logic lvl;
    logic [7:0] dec;

    rst_n = 1'b0;
    v = 1'b0; d = 8'h00;
    v2 = 1'b0; d2 = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte from idle.
    send(8'hA5);
    repeat (50) tick();

    // Two bytes offered continuously, then a third while the holder is full.
    v = 1'b1; d = 8'h00;
    n = 0;
    do begin tick(); n++; end while (!acc_last && n < 200);
    cmp_bit("b2b_first_accept", acc_last, 1'b1);
    d = 8'hFF;
    n = 0;
    do begin tick(); n++; end while (!acc_last && n < 200);
    cmp_bit("b2b_second_accept", acc_last, 1'b1);
    d = 8'h77;
    for (int i = 0; i < 20; i++) begin
      v = 1'($urandom_range(0, 1));
      tick();
    end
    v = 1'b0;
    repeat (120) tick();

    // Reset in the middle of a frame with a byte held.
    send(8'h3C);
    send(8'h81);
    n = 0;
    while (fq.size() > 0 && t < fq[0].s + 14 && n < 200) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (60) tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      tick();
    end
    v = 1'b0;
    repeat (100) tick();

    // Full-rate bit period: one 0x55 frame, measured and decoded.
    cmp_bit("ready2_idle", ready2, 1'b1);
    v2 = 1'b1; d2 = 8'h55;
    tick();
    v2 = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < LOG_N; i++) begin
      tick();
      tx2_log[i] = tx2;
      busy_cnt += int'(busy2);
      done_cnt += int'(done2);
    end
    f = -1;
    for (int i = 0; i < LOG_N; i++) begin
      if (f < 0 && tx2_log[i] == 1'b0) f = i;
    end
    cmp_int("frame2_start_offset", f, 1);
    cmp_int("frame2_busy_cycles", busy_cnt, 10 * C2);
    cmp_int("frame2_done_pulses", done_cnt, 1);
    if (f >= 0 && f + 10 * C2 < LOG_N) begin
      pos = f;
      for (int k = 0; k < 9; k++) begin
        lvl = tx2_log[pos];
        cmp_bit("frame2_bit_level", lvl, (k % 2 == 0) ? 1'b0 : 1'b1);
        len = 0;
        while (pos < LOG_N && tx2_log[pos] == lvl) begin
          len++;
          pos++;
        end
        cmp_int("frame2_bit_len", len, C2);
      end
      for (int i = 0; i < 8; i++) dec[i] = tx2_log[f + (i + 1) * C2 + C2 / 2];
      cmp_int("frame2_decoded", int'(dec), 32'h55);
      cmp_bit("frame2_stop", tx2_log[f + 9 * C2 + C2 / 2], 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 clock  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_data_byte  input  8  byte to send; sampled only on an accept.
REQ-005 i_data_valid  input  1  source offers i_data_byte.
REQ-006 o_ready  output  1  block can accept a byte this cycle.
REQ-007 o_tx  output  1  serial line; idle high; registered.
REQ-008 o_busy  output  1  high while any frame bit is on o_tx.
REQ-009 o_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-010 Frame SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-011 Accept SHALL occur on a rising edge where i_data_valid && o_ready; i_data_byte is captured there.
REQ-012 One-entry holding register; o_ready = holding register empty, combinational from registered state only (no path from i_data_valid).
REQ-013 FSM states IDLE, START, DATA, STOP; default/illegal state -> IDLE with o_tx=1.
REQ-014 IDLE: o_tx=1, o_busy=0; if holding full, load shift register, clear holding, go START; o_tx low on the next edge.
REQ-015 Latency: byte accepted at edge N with block idle and holding empty -> o_tx=0 and o_busy=1 from edge N+2.
REQ-016 START: hold 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: drive shift[bit_index] per bit; after bit 7 go STOP; bit index 3 bits, no wrap beyond 7.
REQ-018 STOP: hold 1 for CLKS_PER_BIT cycles; on final cycle pulse o_done for exactly one cycle.
REQ-019 Back-to-back: if holding full at end of STOP, go directly to START, no idle cycles between stop bit and next start bit; o_busy stays high.
REQ-020 Else end of STOP -> IDLE, o_busy=0.
REQ-021 Accept during any state fills holding only; never alters the frame in flight.
REQ-022 Simultaneous accept and holding drain in the same cycle cannot occur (o_ready=0 when full); i_data_valid while o_ready=0 SHALL be ignored.
REQ-023 Bit counter 16 bits, counts 0..CLKS_PER_BIT-1, resets to 0 at each bit boundary.

Reset
REQ-024 rst_n=0 at an edge SHALL force: state IDLE, o_tx=1, o_busy=0, o_done=0, o_ready=1 after release, holding empty, counters 0.
REQ-025 Reset mid-frame SHALL abort the frame; o_tx returns high on the reset edge; no o_done pulse for the aborted frame; held byte discarded.
REQ-026 No initial-value reliance; all registers defined by reset.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state encodings (2 bits) and the default CLKS_PER_BIT constant, reused by the receive side.
REQ-028 No sub-module; baud counter, FSM, holding register and shift register are inline in uart_tx.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Single byte 0xA5 accepted from idle -> o_tx sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles, starting 2 edges after accept; one o_done pulse; o_busy 40 cycles.
REQ-030 Bytes 0x00 then 0xFF offered continuously -> second accepted during first frame; 80 contiguous busy cycles, no idle gap, two o_done pulses 40 cycles apart.
REQ-031 Third byte offered while holding full -> o_ready=0, byte not captured, line output unaffected until holding drains.
REQ-032 rst_n low at cycle 15 of frame 0x3C with 0x81 held -> o_tx=1, o_busy=0, no o_done, o_ready=1; next accepted 0x81 not sent unless re-offered.
REQ-033 CLKS_PER_BIT=868, byte 0x55 -> each bit exactly 868 cycles, total frame 8680 cycles, loopback into the receiver yields 0x55 with data-available pulse.
REQ-034 i_data_valid toggled with o_ready=0 across a full frame -> no spurious accepts; o_tx matches only accepted bytes.
